// File: rtl/instr_fetch_if.sv
// Instruction-memory read port between the fetch sequencer (master) and memory (slave).
interface instr_fetch_if;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_ready;
    logic [15:0] mem_data;

    modport master (output mem_addr, output mem_rd, input mem_ready, input mem_data);
    modport slave  (input mem_addr, input mem_rd, output mem_ready, output mem_data);
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: reads one word at PC, strobes it into the IR over the
// shared bus for one cycle, then advances PC. Owns PC, branch loads and timeout fault.
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fetch_req,
    input  logic          pc_load,
    input  logic [15:0]   pc_target,
    instr_fetch_if.master mem,
    output logic [15:0]   DATA,
    output logic          bus_drive,
    output logic          IR_in,
    output logic [15:0]   pc,
    output logic          busy,
    output logic          fetch_done,
    output logic          fault
);
    typedef enum logic [1:0] {IDLE, REQ, LOAD} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [1:0]  rst_sync;
    logic        rst_n_sync;
    logic [15:0] pc_q, pc_d;
    logic [15:0] hold_q, hold_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        fault_q, fault_d;

    // Assertion is immediate; release ripples through two flops before the core runs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n_sync = rst_sync[1];

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            hold_q  <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        case (state_q)
            IDLE: begin
                if (pc_load) begin
                    pc_d = pc_target;
                end else if (fetch_req) begin
                    fault_d = 1'b0;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                // cnt_q counts non-ready cycles already spent, so the last allowed one is TIMEOUT-1
                if (mem.mem_ready) begin
                    hold_d  = mem.mem_data;
                    state_d = LOAD;
                end else if (cnt_q == CNT_LAST) begin
                    fault_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            LOAD: begin
                pc_d    = pc_q + 16'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem.mem_addr = pc_q;
    assign mem.mem_rd   = (state_q == REQ);
    assign bus_drive    = (state_q == LOAD);
    assign IR_in        = (state_q == LOAD);
    assign fetch_done   = (state_q == LOAD);
    assign DATA         = bus_drive ? hold_q : 16'h0000;
    assign pc           = pc_q;
    assign busy         = (state_q != IDLE);
    assign fault        = fault_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: zero-wait, wait-state, timeout, branch/wrap,
// reset mid-fetch and ignored-input scenarios with hand-computed expectations.
module tb_instr_fetch;
    logic        clk;
    logic        reset;
    logic        fetch_req;
    logic        pc_load;
    logic [15:0] pc_target;
    logic [15:0] data;
    logic        bus_drive;
    logic        ir_in;
    logic [15:0] pc;
    logic        busy;
    logic        fetch_done;
    logic        fault;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_if mif ();

    instr_fetch #(.RESET_PC(16'h0000), .TIMEOUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_req  (fetch_req),
        .pc_load    (pc_load),
        .pc_target  (pc_target),
        .mem        (mif.master),
        .DATA       (data),
        .bus_drive  (bus_drive),
        .IR_in      (ir_in),
        .pc         (pc),
        .busy       (busy),
        .fetch_done (fetch_done),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Runs one fetch; memory answers in REQ cycle wait_n (negative = never).
    task automatic do_fetch(input int wait_n, input logic [15:0] word,
                            output int rd_n, output int ir_n,
                            output logic [15:0] data_seen, output logic [15:0] addr_seen);
        rd_n = 0;
        ir_n = 0;
        data_seen = 16'h0000;
        addr_seen = 16'h0000;
        fetch_req = 1'b1;
        step;
        fetch_req = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (mif.mem_rd) begin
                rd_n++;
                addr_seen = mif.mem_addr;
            end
            if (ir_in) begin
                ir_n++;
                data_seen = data;
            end
            if (!busy) break;
            mif.mem_ready = mif.mem_rd && (c == wait_n);
            mif.mem_data  = mif.mem_ready ? word : 16'hBEEF;
            step;
        end
        mif.mem_ready = 1'b0;
        mif.mem_data  = 16'h0000;
        check("fetch_bound_idle", 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected end of test");
        $fatal(1, "global timeout");
    end

    initial begin
        int          rd_n;
        int          ir_n;
        logic [15:0] dseen;
        logic [15:0] aseen;

        reset = 1'b0;
        fetch_req = 1'b0;
        pc_load = 1'b0;
        pc_target = 16'h0000;
        mif.mem_ready = 1'b0;
        mif.mem_data = 16'h0000;
        step;
        step;
        check("rst_ctrl_outs", {26'd0, mif.mem_rd, busy, ir_in, bus_drive, fetch_done, fault}, 0);
        check("rst_data", 32'(data), 0);
        check("rst_pc", 32'(pc), 0);
        check("rst_mem_addr", 32'(mif.mem_addr), 0);

        // Release with fetch_req already high: the first edge must not start a fetch.
        reset = 1'b1;
        fetch_req = 1'b1;
        step;
        check("sync_first_edge_busy", 32'(busy), 0);
        fetch_req = 1'b0;
        step;
        step;
        step;
        check("sync_idle_busy", 32'(busy), 0);

        // Zero-wait fetch of mem[0] = 3A5C, traced cycle by cycle.
        fetch_req = 1'b1;
        step;
        fetch_req = 1'b0;
        check("zw_req_rd", 32'(mif.mem_rd), 1);
        check("zw_req_addr", 32'(mif.mem_addr), 0);
        check("zw_req_ir", 32'(ir_in), 0);
        mif.mem_ready = 1'b1;
        mif.mem_data = 16'h3A5C;
        step;
        mif.mem_ready = 1'b0;
        mif.mem_data = 16'hDEAD;
        check("zw_load_strobes", {29'd0, ir_in, bus_drive, fetch_done}, 32'h7);
        check("zw_load_rd", 32'(mif.mem_rd), 0);
        check("zw_load_data", 32'(data), 32'h3A5C);
        check("zw_load_pc", 32'(pc), 0);
        check("zw_load_busy", 32'(busy), 1);
        step;
        check("zw_after_ir", 32'(ir_in), 0);
        check("zw_after_data", 32'(data), 0);
        check("zw_after_pc", 32'(pc), 1);
        check("zw_after_busy", 32'(busy), 0);

        // Three wait states.
        do_fetch(3, 16'hC0DE, rd_n, ir_n, dseen, aseen);
        check("ws_rd_cycles", 32'(rd_n), 4);
        check("ws_ir_pulses", 32'(ir_n), 1);
        check("ws_data", 32'(dseen), 32'hC0DE);
        check("ws_addr", 32'(aseen), 1);
        check("ws_pc", 32'(pc), 2);
        check("ws_fault", 32'(fault), 0);

        // Memory never answers: fault after 4 REQ cycles.
        do_fetch(-1, 16'h0000, rd_n, ir_n, dseen, aseen);
        check("to_rd_cycles", 32'(rd_n), 4);
        check("to_ir_pulses", 32'(ir_n), 0);
        check("to_fault", 32'(fault), 1);
        check("to_pc", 32'(pc), 2);
        step;
        check("to_fault_sticky", 32'(fault), 1);

        // Next accepted fetch clears the fault.
        fetch_req = 1'b1;
        step;
        fetch_req = 1'b0;
        check("clr_fault_in_req", 32'(fault), 0);
        mif.mem_ready = 1'b1;
        mif.mem_data = 16'h1111;
        step;
        mif.mem_ready = 1'b0;
        check("clr_data", 32'(data), 32'h1111);
        step;
        check("clr_pc", 32'(pc), 3);

        // pc_load beats a simultaneous fetch_req.
        pc_load = 1'b1;
        pc_target = 16'hFFFF;
        fetch_req = 1'b1;
        step;
        pc_load = 1'b0;
        fetch_req = 1'b0;
        check("br_pc", 32'(pc), 32'hFFFF);
        check("br_busy", 32'(busy), 0);
        check("br_mem_addr", 32'(mif.mem_addr), 32'hFFFF);
        step;
        check("br_no_fetch", 32'(busy), 0);
        do_fetch(0, 16'h7E57, rd_n, ir_n, dseen, aseen);
        check("wrap_addr", 32'(aseen), 32'hFFFF);
        check("wrap_data", 32'(dseen), 32'h7E57);
        check("wrap_pc", 32'(pc), 0);

        // pc_load / fetch_req during REQ and LOAD are ignored.
        fetch_req = 1'b1;
        step;
        pc_load = 1'b1;
        pc_target = 16'h1234;
        step;
        step;
        mif.mem_ready = 1'b1;
        mif.mem_data = 16'hABCD;
        step;
        mif.mem_ready = 1'b0;
        check("ign_load_ir", 32'(ir_in), 1);
        check("ign_load_data", 32'(data), 32'hABCD);
        step;
        pc_load = 1'b0;
        fetch_req = 1'b0;
        check("ign_pc", 32'(pc), 1);
        check("ign_idle", 32'(busy), 0);
        step;
        check("ign_no_second", {30'd0, busy, ir_in}, 0);
        check("ign_pc_stable", 32'(pc), 1);

        // Reset mid-fetch, then a late memory response.
        fetch_req = 1'b1;
        step;
        fetch_req = 1'b0;
        check("mid_req_rd", 32'(mif.mem_rd), 1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_outs", {26'd0, mif.mem_rd, busy, ir_in, bus_drive, fetch_done, fault}, 0);
        check("mid_rst_pc", 32'(pc), 0);
        check("mid_rst_addr", 32'(mif.mem_addr), 0);
        mif.mem_ready = 1'b1;
        mif.mem_data = 16'h5555;
        step;
        check("mid_rst_no_ir", 32'(ir_in), 0);
        reset = 1'b1;
        ir_n = 0;
        for (int i = 0; i < 4; i++) begin
            step;
            if (ir_in || busy) ir_n++;
        end
        mif.mem_ready = 1'b0;
        check("mid_late_ready_ignored", 32'(ir_n), 0);
        check("mid_data", 32'(data), 0);

        // Normal operation resumes.
        do_fetch(0, 16'h0F0F, rd_n, ir_n, dseen, aseen);
        check("post_data", 32'(dseen), 32'h0F0F);
        check("post_rd_cycles", 32'(rd_n), 1);
        check("post_pc", 32'(pc), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
